// File: rtl/axis_oq_writer.sv
// AXI-Stream to SRAM output-queue write path: per-packet admission against
// per-queue occupancy, 1-deep output register, and occupancy tracking.
module axis_oq_writer #(
  parameter int DATA_WIDTH    = 256,
  parameter int TUSER_WIDTH   = 128,
  parameter int NUM_QUEUES    = 5,
  parameter int DST_LSB       = 24,
  parameter int QUEUE_WORDS   = 4096,
  parameter int MAX_PKT_WORDS = 48,
  localparam int QID_W        = $clog2(NUM_QUEUES),
  localparam int OCC_W        = $clog2(QUEUE_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [DATA_WIDTH-1:0]       s_tdata,
  input  logic [DATA_WIDTH/8-1:0]     s_tstrb,
  input  logic [TUSER_WIDTH-1:0]      s_tuser,
  input  logic                        s_tlast,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [DATA_WIDTH-1:0]       mem_data,
  output logic [DATA_WIDTH/8-1:0]     mem_strb,
  output logic [QID_W-1:0]            mem_qid,
  output logic                        mem_sop,
  output logic                        mem_eop,
  input  logic                        deq_valid,
  input  logic [QID_W-1:0]            deq_qid,
  input  logic [OCC_W-1:0]            deq_words,
  output logic [NUM_QUEUES*OCC_W-1:0] occ,
  output logic [31:0]                 drop_count,
  output logic [31:0]                 pkt_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]                  state;
  logic                        pkt_open;
  logic [QID_W-1:0]            cur_qid;
  logic [NUM_QUEUES-1:0]       dst_field;
  logic [QID_W-1:0]            dst_qid;
  logic [OCC_W-1:0]            dst_occ;
  logic                        admit_ok;
  logic                        in_hs, mem_hs, first_beat, take;
  logic [OCC_W:0]              sum, sub;
  logic [NUM_QUEUES*OCC_W-1:0] occ_nxt;
  logic                        unused_tuser;

  assign unused_tuser = ^s_tuser;
  assign dst_field    = s_tuser[DST_LSB +: NUM_QUEUES];

  always_comb begin
    dst_qid = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++)
      if (dst_field[NUM_QUEUES-1-i]) dst_qid = QID_W'(NUM_QUEUES-1-i);
  end

  assign dst_occ  = occ[dst_qid*OCC_W +: OCC_W];
  assign admit_ok = (|dst_field) &&
                    ((32'(dst_occ) + 32'(MAX_PKT_WORDS)) <= 32'(QUEUE_WORDS));

  assign s_tready   = resetn & ((state == ST_DROP) | ~mem_valid | mem_ready);
  assign in_hs      = s_tvalid & s_tready;
  assign mem_hs     = mem_valid & mem_ready;
  // IDLE with pkt_open set means a reset cut a packet short: discard to its tlast
  assign first_beat = (state == ST_IDLE) & ~pkt_open;
  assign take       = in_hs & ((state == ST_WRITE) | (first_beat & admit_ok));

  // Deliberately outside the reset domain so it survives a mid-packet reset
  always_ff @(posedge clk) begin
    if (in_hs) pkt_open <= ~s_tlast;
  end

  always_comb begin
    occ_nxt = occ;
    sum     = '0;
    sub     = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      sum = {1'b0, occ[q*OCC_W +: OCC_W]} +
            {{OCC_W{1'b0}}, (mem_hs && (mem_qid == QID_W'(q)))};
      sub = (deq_valid && (deq_qid == QID_W'(q))) ? {1'b0, deq_words} : '0;
      occ_nxt[q*OCC_W +: OCC_W] = (sum > sub) ? OCC_W'(sum - sub) : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      cur_qid    <= '0;
      mem_valid  <= 1'b0;
      mem_data   <= '0;
      mem_strb   <= '0;
      mem_qid    <= '0;
      mem_sop    <= 1'b0;
      mem_eop    <= 1'b0;
      occ        <= '0;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      occ <= occ_nxt;
      if (mem_hs) mem_valid <= 1'b0;
      if (take) begin
        mem_valid <= 1'b1;
        mem_data  <= s_tdata;
        mem_strb  <= s_tstrb;
        mem_qid   <= first_beat ? dst_qid : cur_qid;
        mem_sop   <= first_beat;
        mem_eop   <= s_tlast;
      end
      if (mem_hs && mem_eop) pkt_count <= pkt_count + 32'd1;
      if (in_hs) begin
        case (state)
          ST_IDLE: begin
            if (first_beat) begin
              if (admit_ok) begin
                cur_qid <= dst_qid;
                if (!s_tlast) state <= ST_WRITE;
              end else begin
                drop_count <= drop_count + 32'd1;
                if (!s_tlast) state <= ST_DROP;
              end
            end
          end
          ST_WRITE, ST_DROP: if (s_tlast) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_oq_writer.sv
// Randomized bench for axis_oq_writer with a packet-level scoreboard and
// occupancy model, plus directed admission, drop and reset scenarios.
module tb_axis_oq_writer;
  localparam int DW = 256, TW = 128, NQ = 5, DST = 24, QW = 4096, MAXP = 48;
  localparam int QID_W = 3, OCC_W = 13;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]          s_tdata;
  logic [DW/8-1:0]        s_tstrb;
  logic [TW-1:0]          s_tuser;
  logic                   mem_valid, mem_ready, mem_sop, mem_eop;
  logic [DW-1:0]          mem_data;
  logic [DW/8-1:0]        mem_strb;
  logic [QID_W-1:0]       mem_qid;
  logic                   deq_valid;
  logic [QID_W-1:0]       deq_qid;
  logic [OCC_W-1:0]       deq_words;
  logic [NQ*OCC_W-1:0]    occ;
  logic [31:0]            drop_count, pkt_count;

  axis_oq_writer #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(TW), .NUM_QUEUES(NQ), .DST_LSB(DST),
    .QUEUE_WORDS(QW), .MAX_PKT_WORDS(MAXP)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_strb(mem_strb),
    .mem_qid(mem_qid), .mem_sop(mem_sop), .mem_eop(mem_eop),
    .deq_valid(deq_valid), .deq_qid(deq_qid), .deq_words(deq_words),
    .occ(occ), .drop_count(drop_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    int              q;
    bit              sop;
    bit              eop;
  } word_t;

  word_t sb[$];
  int    m_occ[NQ];
  int    m_drop_cnt = 0, m_pkt_cnt = 0, cur_q = 0;
  bit    m_inpkt = 0, m_drop = 0, m_discard = 0;
  int    checks = 0, failures = 0;
  int    rdy_mode = 0;
  bit    deq_rand = 0, dq_req = 0;
  int    dq_q = 0, dq_w = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [NQ-1:0] f);
    int r = -1;
    for (int i = NQ - 1; i >= 0; i--) if (f[i]) r = i;
    return r;
  endfunction

  // Reference model: compare state at the negedge, then apply the events of the next posedge
  always @(negedge clk) begin
    word_t w;
    int    inc[NQ];
    bit    exp_rdy, in_hs, m_hs;
    int    v, q;
    if (!resetn) begin
      check("rst_ctl", {s_tready, mem_valid, mem_sop, mem_eop}, '0);
      check("rst_data", mem_data, '0);
      check("rst_occ", occ, '0);
      check("rst_cnt", {drop_count, pkt_count}, '0);
      m_discard = m_discard | m_inpkt;
      m_inpkt = 0; m_drop = 0; sb.delete();
      foreach (m_occ[i]) m_occ[i] = 0;
      m_drop_cnt = 0; m_pkt_cnt = 0;
    end else begin
      exp_rdy = (m_inpkt && m_drop) || (sb.size() == 0) || mem_ready;
      check("s_tready", s_tready, exp_rdy);
      check("mem_valid", mem_valid, sb.size() != 0);
      if (sb.size() != 0 && mem_valid) begin
        check("mem_data", mem_data, sb[0].data);
        check("mem_strb", mem_strb, sb[0].strb);
        check("mem_qid", mem_qid, sb[0].q);
        check("mem_sop_eop", {mem_sop, mem_eop}, {sb[0].sop, sb[0].eop});
      end
      for (int i = 0; i < NQ; i++) check($sformatf("occ%0d", i), occ[i*OCC_W +: OCC_W], m_occ[i]);
      check("drop_count", drop_count, m_drop_cnt);
      check("pkt_count", pkt_count, m_pkt_cnt);

      foreach (inc[i]) inc[i] = 0;
      m_hs  = (sb.size() != 0) && mem_ready;
      in_hs = s_tvalid && exp_rdy;
      if (m_hs) begin
        w = sb.pop_front();
        inc[w.q] = 1;
        if (w.eop) m_pkt_cnt++;
      end
      if (in_hs) begin
        w.data = s_tdata; w.strb = s_tstrb; w.eop = s_tlast;
        if (m_discard) begin
          if (s_tlast) m_discard = 0;
        end else if (!m_inpkt) begin
          q = lowest_set(s_tuser[DST +: NQ]);
          if (q >= 0 && m_occ[q] + MAXP <= QW) begin
            m_drop = 0; cur_q = q;
            w.q = q; w.sop = 1; sb.push_back(w);
          end else begin
            m_drop = 1; m_drop_cnt++;
          end
          m_inpkt = !s_tlast;
        end else begin
          if (!m_drop) begin w.q = cur_q; w.sop = 0; sb.push_back(w); end
          if (s_tlast) m_inpkt = 0;
        end
      end
      for (int i = 0; i < NQ; i++) begin
        v = m_occ[i] + inc[i];
        if (deq_valid && deq_qid == i) v = v - int'(deq_words);
        m_occ[i] = (v < 0) ? 0 : v;
      end
    end
  end

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = !mem_ready;
        default: mem_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin
    deq_valid = 0; deq_qid = '0; deq_words = '0;
    forever begin
      @(posedge clk); #2;
      if (dq_req) begin
        deq_valid = 1; deq_qid = QID_W'(dq_q); deq_words = OCC_W'(dq_w); dq_req = 0;
      end else if (deq_rand && $urandom_range(7) == 0) begin
        deq_valid = 1; deq_qid = QID_W'($urandom_range(7)); deq_words = OCC_W'($urandom_range(60));
      end else deq_valid = 0;
    end
  end

  task automatic do_deq(input int q, input int w);
    dq_q = q; dq_w = w; dq_req = 1;
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] dst8, input int base,
                          input logic [DW/8-1:0] last_strb, input int rst_beat, input int gap_pct);
    bit ok;
    int t;
    for (int b = 0; b < len; b++) begin
      if (b == rst_beat) begin
        s_tvalid = 0; resetn = 0; #1;
        check("rst_async_tready", s_tready, 0);
        check("rst_async_valid", mem_valid, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1;
      end
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 0; @(posedge clk); #1;
      end
      s_tvalid = 1;
      s_tdata  = DW'(base + b);
      s_tstrb  = (b == len - 1) ? last_strb : '1;
      s_tlast  = (b == len - 1);
      s_tuser  = {$urandom, $urandom, $urandom, $urandom};
      if (b == 0) s_tuser[31:24] = dst8;
      t = 0;
      do begin
        @(negedge clk); ok = s_tready;
        @(posedge clk); #1; t++;
      end while (!ok && t < 2000);
      if (!ok) check("tready_timeout", 0, 1);
    end
    s_tvalid = 0; s_tlast = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    #1 check("drain", sb.size(), 0);
  endtask

  function automatic int occ_of(input int q);
    return int'(occ[q*OCC_W +: OCC_W]);
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 0; s_tvalid = 0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    @(posedge clk); #1;

    // 51-beat packets to q0 and q1
    send_pkt(51, 8'hAF, 50, 32'h000fffff, -1, 0);
    send_pkt(51, 8'hEA, 200, '1, -1, 0);
    wait_drain();
    check("t1_occ0", occ_of(0), 51);
    check("t1_occ1", occ_of(1), 51);
    check("t1_pkts", pkt_count, 2);

    // Write and dequeue on the same queue in one cycle, then saturation
    fork
      send_pkt(10, 8'h01, 600, '1, -1, 0);
      begin repeat (4) @(posedge clk); #1; do_deq(0, 5); end
    join
    wait_drain();
    check("t5_net", occ_of(0), 56);
    do_deq(1, 4095);
    @(posedge clk); #1;
    check("t5_sat", occ_of(1), 0);

    // Fill q2 to QUEUE_WORDS-47, then a dropped and an admitted packet
    for (int i = 0; i < 79; i++) send_pkt(51, 8'h04, 1000 + i * 64, '1, -1, 0);
    send_pkt(20, 8'h04, 9000, '1, -1, 0);
    wait_drain();
    check("t3_fill", occ_of(2), QW - 47);
    send_pkt(10, 8'h04, 9100, '1, -1, 0);
    wait_drain();
    check("t3_drop", drop_count, 1);
    check("t3_occ_hold", occ_of(2), QW - 47);
    do_deq(2, 1);
    send_pkt(10, 8'h04, 9200, '1, -1, 0);
    wait_drain();
    check("t3_admit", occ_of(2), QW - 38);
    check("t3_pkts", pkt_count, 84);

    // Empty destination field
    send_pkt(7, 8'hE0, 9300, '1, -1, 0);
    wait_drain();
    check("t4_drop", drop_count, 2);

    // Toggling backpressure
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send_pkt(int'($urandom_range(1, 30)), 8'h02, 10000 + i * 64, '1, -1, 0);
    wait_drain();

    // Random traffic with random backpressure and dequeues
    rdy_mode = 2; deq_rand = 1;
    for (int i = 0; i < 40; i++)
      send_pkt(int'($urandom_range(1, 60)), 8'($urandom), 20000 + i * 64,
               DW/8'($urandom), -1, 20);
    wait_drain();
    deq_rand = 0; rdy_mode = 0;
    repeat (3) @(posedge clk); #1;

    // Reset mid-packet, then a clean packet
    send_pkt(51, 8'h08, 30000, '1, 20, 0);
    send_pkt(12, 8'h10, 31000, '1, -1, 0);
    wait_drain();
    check("t6_pkts", pkt_count, 1);
    check("t6_occ3", occ_of(3), 0);
    check("t6_occ4", occ_of(4), 12);
    check("t6_drops", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
